// File: rtl/rtc_bus_if.sv
// rtc_bus_if
// Host-side strobe bus of the RTC-style multiplexed parallel interface.
//   AD, RD, CS, WR : active-low strobes from the host (AD=0 selects address phase)
//   bus_in         : byte driven by the host
//   tick_1hz       : single-cycle timekeeping pulse
//   bus_out/bus_oe : read data and drive enable from the responder
//   proto_err      : single-cycle pulse on an illegal strobe combination
//   state_dbg      : responder bus FSM state, for observation only
interface rtc_bus_if;
    logic       AD;
    logic       RD;
    logic       CS;
    logic       WR;
    logic [7:0] bus_in;
    logic       tick_1hz;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       proto_err;
    logic [1:0] state_dbg;

    modport master (
        output AD, RD, CS, WR, bus_in, tick_1hz,
        input  bus_out, bus_oe, proto_err, state_dbg
    );

    modport slave (
        input  AD, RD, CS, WR, bus_in, tick_1hz,
        output bus_out, bus_oe, proto_err, state_dbg
    );
endinterface

// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder
// Behavioural RTC chip on the far end of the multiplexed AD/RD/CS/WR bus.
// Latches addresses, accepts writes, drives read data and keeps a BCD
// seconds/minutes/hours counter advanced by tick_1hz.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : rtc_bus_if.slave (strobes, bus_in, tick_1hz in; bus_out, bus_oe,
//           proto_err, state_dbg out)
//
// Strobe protocol: a transaction starts when CS and WR (or RD) are low and is
// committed when WR/RD or CS returns high. AD=0 with WR=0 is an address phase,
// AD=1 with WR=0 a data write, AD=1 with RD=0 a read. The byte committed is the
// one present in the last cycle the strobe was low. RD and WR low together
// under CS is illegal and is flagged once until the strobes clear.
module rtc_bus_responder #(
    parameter int                 ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]  SEC_ADDR  = 8'h21,
    parameter logic [ADDR_W-1:0]  MIN_ADDR  = 8'h22,
    parameter logic [ADDR_W-1:0]  HOUR_ADDR = 8'h23
) (
    input  logic       clk,
    input  logic       reset,
    rtc_bus_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2,
        READ  = 2'd3
    } state_t;

    // two-flop synchronizers
    logic       ad_m, rd_m, cs_m, wr_m;
    logic       s_ad, s_rd, s_cs, s_wr;
    logic [7:0] bus_m, s_bus;

    always_ff @(posedge clk) begin
        if (reset) begin
            ad_m  <= 1'b1; rd_m <= 1'b1; cs_m <= 1'b1; wr_m <= 1'b1;
            s_ad  <= 1'b1; s_rd <= 1'b1; s_cs <= 1'b1; s_wr <= 1'b1;
            bus_m <= 8'h00;
            s_bus <= 8'h00;
        end else begin
            ad_m  <= bus.AD; rd_m <= bus.RD; cs_m <= bus.CS; wr_m <= bus.WR;
            s_ad  <= ad_m;   s_rd <= rd_m;   s_cs <= cs_m;   s_wr <= wr_m;
            bus_m <= bus.bus_in;
            s_bus <= bus_m;
        end
    end

    logic [7:0]        mem [0:DEPTH-1];
    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wd_q;        // most recent bus sample while the strobe is low
    logic [7:0]        bus_out_q;
    logic              bus_oe_q;
    logic              proto_err_q;
    logic              locked;      // ignore strobes until the bus has been seen idle
    logic [1:0]        arm_cnt;     // lets the synchronizers refill after reset
    logic              tick_pend;

    logic illegal, all_high, wr_commit, time_hit, tick_any;

    assign illegal   = !s_cs && !s_rd && !s_wr;
    assign all_high  = s_rd && s_wr && s_cs;
    // Release and the illegal combination are mutually exclusive, so a WDATA
    // state seeing a released strobe is always a clean commit.
    assign wr_commit = (state == WDATA) && (s_wr || s_cs);
    assign time_hit  = wr_commit &&
                       (addr_q == SEC_ADDR || addr_q == MIN_ADDR || addr_q == HOUR_ADDR);
    assign tick_any  = bus.tick_1hz || tick_pend;

    // Bus FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            addr_q      <= '0;
            wd_q        <= 8'h00;
            bus_out_q   <= 8'h00;
            bus_oe_q    <= 1'b0;
            proto_err_q <= 1'b0;
            locked      <= 1'b1;
            arm_cnt     <= 2'd0;
        end else begin
            proto_err_q <= 1'b0;
            if (arm_cnt != 2'd2) arm_cnt <= arm_cnt + 2'd1;

            if (illegal && !locked) begin
                proto_err_q <= 1'b1;
                locked      <= 1'b1;
                state       <= IDLE;
                bus_oe_q    <= 1'b0;
            end else if (locked) begin
                state    <= IDLE;
                bus_oe_q <= 1'b0;
                // Synchronizer outputs are only trusted once refilled after reset.
                if (arm_cnt == 2'd2 && all_high) locked <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!s_cs) begin
                            if (!s_wr) begin
                                wd_q  <= s_bus;
                                state <= s_ad ? WDATA : ADDR;
                            end else if (s_ad && !s_rd) begin
                                state     <= READ;
                                bus_oe_q  <= 1'b1;
                                bus_out_q <= mem[addr_q];
                            end
                        end
                    end
                    ADDR: begin
                        if (s_wr || s_cs) begin
                            addr_q <= wd_q[ADDR_W-1:0];
                            state  <= IDLE;
                        end else begin
                            wd_q <= s_bus;
                        end
                    end
                    WDATA: begin
                        if (s_wr || s_cs) state <= IDLE;
                        else              wd_q  <= s_bus;
                    end
                    READ: begin
                        if (s_rd || s_cs) begin
                            state    <= IDLE;
                            bus_oe_q <= 1'b0;
                        end else begin
                            bus_oe_q  <= 1'b1;
                            bus_out_q <= mem[addr_q];
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Nibble increment: low nibble 9 or F rolls to 0 and carries into the high nibble.
    function automatic logic [7:0] nib_inc(input logic [7:0] v);
        if (v[3:0] == 4'h9 || v[3:0] == 4'hF) nib_inc = {v[7:4] + 4'h1, 4'h0};
        else                                  nib_inc = v + 8'h01;
    endfunction

    // Register file and timekeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
            tick_pend <= 1'b0;
        end else begin
            if (wr_commit) mem[addr_q] <= wd_q;
            if (tick_any) begin
                if (time_hit) begin
                    // host write wins; the tick is applied next cycle
                    tick_pend <= 1'b1;
                end else begin
                    tick_pend <= 1'b0;
                    if (mem[SEC_ADDR] == 8'h59) begin
                        mem[SEC_ADDR] <= 8'h00;
                        if (mem[MIN_ADDR] == 8'h59) begin
                            mem[MIN_ADDR]  <= 8'h00;
                            mem[HOUR_ADDR] <= (mem[HOUR_ADDR] == 8'h23) ? 8'h00
                                                                        : nib_inc(mem[HOUR_ADDR]);
                        end else begin
                            mem[MIN_ADDR] <= nib_inc(mem[MIN_ADDR]);
                        end
                    end else begin
                        mem[SEC_ADDR] <= nib_inc(mem[SEC_ADDR]);
                    end
                end
            end
        end
    end

    assign bus.bus_out   = bus_out_q;
    assign bus.bus_oe    = bus_oe_q;
    assign bus.proto_err = proto_err_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_rtc_bus_responder.sv
// tb_rtc_bus_responder
// Directed and randomized host transactions against rtc_bus_responder, with a
// byte-array reference model of the register file and clock rules.
module tb_rtc_bus_responder;
    localparam logic [7:0] SEC  = 8'h21;
    localparam logic [7:0] MIN  = 8'h22;
    localparam logic [7:0] HOUR = 8'h23;

    logic clk;
    logic reset;
    rtc_bus_if bif();

    rtc_bus_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model and scoreboard
    int         tests = 0;
    int         fails = 0;
    logic [7:0] model_mem [256];
    logic [7:0] model_addr;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_nib_inc(input logic [7:0] v);
        int hi, lo;
        hi = int'(v) / 16;
        lo = int'(v) % 16;
        if (lo == 9 || lo == 15) return 8'(((hi + 1) % 16) * 16);
        return 8'(int'(v) + 1);
    endfunction

    task automatic model_tick();
        if (model_mem[SEC] == 8'h59) begin
            model_mem[SEC] = 8'h00;
            if (model_mem[MIN] == 8'h59) begin
                model_mem[MIN]  = 8'h00;
                model_mem[HOUR] = (model_mem[HOUR] == 8'h23) ? 8'h00 : model_nib_inc(model_mem[HOUR]);
            end else begin
                model_mem[MIN] = model_nib_inc(model_mem[MIN]);
            end
        end else begin
            model_mem[SEC] = model_nib_inc(model_mem[SEC]);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
        model_addr = 8'h00;
    endtask

    // driver tasks
    task automatic bus_idle();
        bif.AD = 1'b1; bif.RD = 1'b1; bif.CS = 1'b1; bif.WR = 1'b1;
    endtask

    // Address (is_addr=1) or data strobe; with late=1 the correct byte only
    // appears in the last low cycle. tick_on_commit fires tick_1hz in the
    // commit cycle (third edge after release).
    task automatic bus_strobe(input bit is_addr, input logic [7:0] v, input bit late,
                              input bit tick_on_commit);
        int w;
        w = $urandom_range(3, 6);
        @(negedge clk);
        bif.CS = 1'b0; bif.AD = !is_addr; bif.WR = 1'b0;
        bif.bus_in = late ? ~v : v;
        repeat (w - 1) @(negedge clk);
        bif.bus_in = v;
        @(negedge clk);
        bus_idle();
        @(negedge clk);
        @(negedge clk);
        if (tick_on_commit) bif.tick_1hz = 1'b1;
        @(negedge clk);
        bif.tick_1hz = 1'b0;
        @(negedge clk);
        if (is_addr) begin
            model_addr = v;
        end else begin
            model_mem[model_addr] = v;
            if (tick_on_commit) model_tick();
        end
    endtask

    task automatic bus_read(input string tag, input bit chk_lat);
        logic [7:0] exp;
        exp = exp_q.pop_front();
        @(negedge clk);
        bif.CS = 1'b0; bif.AD = 1'b1; bif.RD = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (chk_lat) check({tag, "_oe_early"}, {7'd0, bif.bus_oe}, 8'h00);
        @(negedge clk);
        check({tag, "_oe"}, {7'd0, bif.bus_oe}, 8'h01);
        check({tag, "_data"}, bif.bus_out, exp);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        bus_idle();
        @(negedge clk);
        @(negedge clk);
        if (chk_lat) check({tag, "_oe_hold"}, {7'd0, bif.bus_oe}, 8'h01);
        @(negedge clk);
        check({tag, "_oe_off"}, {7'd0, bif.bus_oe}, 8'h00);
        @(negedge clk);
    endtask

    task automatic write_at(input logic [7:0] a, input logic [7:0] d);
        bus_strobe(1'b1, a, 1'b0, 1'b0);
        bus_strobe(1'b0, d, 1'b0, 1'b0);
    endtask

    task automatic read_at(input string tag, input logic [7:0] a);
        bus_strobe(1'b1, a, 1'b0, 1'b0);
        exp_q.push_back(model_mem[a]);
        bus_read(tag, 1'b0);
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        bif.tick_1hz = 1'b1;
        @(negedge clk);
        bif.tick_1hz = 1'b0;
        model_tick();
    endtask

    // stimulus
    initial begin
        int pulses;
        int oe_seen;
        logic [7:0] a, d;

        bus_idle();
        bif.bus_in   = 8'h00;
        bif.tick_1hz = 1'b0;
        model_clear();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_bus_out", bif.bus_out, 8'h00);
        check("rst_bus_oe", {7'd0, bif.bus_oe}, 8'h00);
        check("rst_proto_err", {7'd0, bif.proto_err}, 8'h00);
        repeat (3) @(negedge clk);

        // address 05, data A7, read back with latency checks
        @(negedge clk);
        bif.CS = 1'b0; bif.AD = 1'b0; bif.WR = 1'b0; bif.bus_in = 8'h05;
        repeat (6) @(negedge clk);
        bus_idle();
        repeat (4) @(negedge clk);
        model_addr = 8'h05;
        bus_strobe(1'b0, 8'hA7, 1'b0, 1'b0);
        exp_q.push_back(model_mem[8'h05]);
        bus_read("rd_a7", 1'b1);

        // late-settling write data
        bus_strobe(1'b1, 8'h06, 1'b0, 1'b0);
        bus_strobe(1'b0, 8'h3E, 1'b1, 1'b0);
        read_at("late_data", 8'h06);

        // full rollover 23:59:59 -> 00:00:00
        write_at(SEC, 8'h59);
        write_at(MIN, 8'h59);
        write_at(HOUR, 8'h23);
        pulse_tick();
        read_at("roll_sec", SEC);
        read_at("roll_min", MIN);
        read_at("roll_hour", HOUR);

        // minute carry without hour carry
        write_at(SEC, 8'h59);
        write_at(MIN, 8'h09);
        pulse_tick();
        read_at("carry_sec", SEC);
        read_at("carry_min", MIN);

        // tick collides with a seconds write
        bus_strobe(1'b1, SEC, 1'b0, 1'b0);
        bus_strobe(1'b0, 8'h30, 1'b0, 1'b1);
        read_at("collide_sec", SEC);

        // illegal strobe combination
        write_at(8'h40, 8'h3C);
        pulses  = 0;
        oe_seen = 0;
        @(negedge clk);
        bif.CS = 1'b0; bif.AD = 1'b1; bif.RD = 1'b0; bif.WR = 1'b0; bif.bus_in = 8'hFF;
        repeat (8) begin
            @(negedge clk);
            if (bif.proto_err) pulses++;
            if (bif.bus_oe) oe_seen++;
        end
        bus_idle();
        repeat (4) begin
            @(negedge clk);
            if (bif.proto_err) pulses++;
            if (bif.bus_oe) oe_seen++;
        end
        check("err_pulses", 8'(pulses), 8'd1);
        check("err_oe", 8'(oe_seen), 8'd0);
        exp_q.push_back(model_mem[model_addr]);
        bus_read("err_mem", 1'b0);

        // strobes toggled with CS high
        repeat (16) begin
            @(negedge clk);
            bif.CS = 1'b1;
            bif.AD = 1'($urandom_range(0, 1));
            bif.RD = 1'($urandom_range(0, 1));
            bif.WR = 1'($urandom_range(0, 1));
            bif.bus_in = 8'($urandom);
            check("cs_hi_oe", {7'd0, bif.bus_oe}, 8'h00);
            check("cs_hi_err", {7'd0, bif.proto_err}, 8'h00);
        end
        bus_idle();
        repeat (4) @(negedge clk);
        exp_q.push_back(model_mem[model_addr]);
        bus_read("cs_hi_mem", 1'b0);

        // randomized traffic with occasional ticks
        for (int n = 0; n < 16; n++) begin
            a = 8'($urandom_range(0, 255));
            d = 8'($urandom);
            if (n % 4 == 0) a = 8'($urandom_range(int'(SEC), int'(HOUR)));
            bus_strobe(1'b1, a, 1'b0, 1'b0);
            bus_strobe(1'b0, d, 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 2) == 0) pulse_tick();
            read_at("rand_rd", a);
            if (n % 4 == 0) begin
                pulse_tick();
                read_at("rand_sec", SEC);
                read_at("rand_min", MIN);
            end
        end

        // reset during an active read
        @(negedge clk);
        bif.CS = 1'b0; bif.AD = 1'b1; bif.RD = 1'b0;
        repeat (3) @(negedge clk);
        check("rr_oe_before", {7'd0, bif.bus_oe}, 8'h01);
        reset = 1'b1;
        @(negedge clk);
        check("rr_oe_reset", {7'd0, bif.bus_oe}, 8'h00);
        reset = 1'b0;
        model_clear();
        oe_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bif.bus_oe) oe_seen++;
        end
        check("rr_inflight_oe", 8'(oe_seen), 8'd0);
        bus_idle();
        repeat (4) @(negedge clk);
        exp_q.push_back(model_mem[8'h00]);
        bus_read("rr_addr0", 1'b0);
        read_at("rr_sec", SEC);
        read_at("rr_min", MIN);
        read_at("rr_hour", HOUR);
        read_at("rr_a7", 8'h05);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
